adc_scan_master: RTL
====================

// Module: adc_scan_master
// PURPOSE
//  Bus-side initiator for the 4-channel A/D port: drives channel address, a write
//  (start-conversion) strobe, waits out conversion time, then a read strobe, and
//  captures the 8-bit result per channel. Scans enabled channels on vblank rise or
//  a start pulse; feeds control logic that needs stick values without a CPU cycle.
// PARAMETERS
//  WR_CYCLES    2   wr_n low time per channel, cycles (>=1)
//  CONV_CYCLES  8   idle wait between wr_n release and rd_n assert (>=1)
//  RD_CYCLES    2   rd_n low time; data sampled on last rd_n-low edge (>=2)
//  USE_VBLANK   1   1: vblank rising edge triggers a scan; 0: start only
// PORTS
//  clk6m     in   1   6 MHz system clock; all logic on rising edge
//  reset     in   1   synchronous, active-high
//  vblank    in   1   video vertical blank, level
//  start     in   1   one-cycle scan request
//  chan_en   in   4   channel enable mask, latched at trigger
//  a         out  2   channel address to A/D
//  wr_n      out  1   start-conversion strobe, active low
//  rd_n      out  1   read strobe, active low
//  data_in   in   16  A/D read data; only [7:0] used
//  results   out  32  {ch3,ch2,ch1,ch0} captured bytes
//  valid     out  4   sticky per-channel captured flag
//  busy      out  1   scan in progress
//  done      out  1   one-cycle pulse at scan end
//  overrun   out  1   one-cycle pulse: trigger arrived while busy
// BEHAVIOUR
//  Reset: state IDLE, a=0, wr_n=1, rd_n=1, results=0, valid=0, busy=0, done=0,
//   overrun=0, vblank history=0. Reset mid-scan aborts immediately, strobes high.
//  trig = start | (USE_VBLANK & vblank & ~vblank_q); vblank_q registered each edge.
//  States: IDLE -> SETUP -> WR -> CONV -> RD -> (SETUP next ch | IDLE).
//  IDLE: on trig latch chan_en into mask; mask==0 -> done=1 next cycle, stay IDLE;
//   else busy=1, ch = lowest set bit, -> SETUP.
//  SETUP: 1 cycle, a=ch, wr_n=1, rd_n=1.
//  WR: WR_CYCLES cycles wr_n=0. CONV: CONV_CYCLES cycles, both strobes high.
//  RD: RD_CYCLES cycles rd_n=0; at edge ending final RD cycle results[8*ch+:8] <=
//   data_in[7:0], valid[ch] <= 1, clear mask[ch].
//  After RD: remaining mask -> SETUP with next-lowest channel; else IDLE, busy=0,
//   done=1 for one cycle (same edge).
//  a held constant SETUP..RD; wr_n and rd_n never low in same cycle; all outputs
//   registered.
//  Per-channel time = 1+WR+CONV+RD (defaults 13); 4 channels = 52 cycles trigger-
//   edge to done.
//  trig while busy: ignored, overrun pulses 1 cycle; scan continues unchanged.
//  start and vblank rise same cycle: one scan. chan_en changes mid-scan: no effect.
//  valid bits clear only on reset; results hold until overwritten.
//  Counters sized for parameter max; no wrap possible within a phase.
// TESTING
//  1 Reset mid-RD of ch1 -> next cycle wr_n=rd_n=1, a=0, results=0, valid=0, busy=0.
//  2 Fixture responder analog=16'hA05F, chan_en=4'hF, start -> results=32'h5F7FA07F,
//    valid=4'hF, done exactly 52 cycles after start edge.
//  3 chan_en=4'b1010 -> only a=1 then a=3 cycles, 26 cycles to done, valid=4'b1010.
//  4 chan_en=0, start -> no strobe activity, done pulse next cycle, busy stays 0.
//  5 start again 10 cycles into scan -> overrun 1-cycle pulse, single done.
//  6 USE_VBLANK=1, vblank 0->1 held 100 cycles -> exactly one scan; USE_VBLANK=0 -> none.

Source files
------------

// File: rtl/adc_scan_master.sv
// ---------------------------------------------------------------------------
// adc_scan_master
//   Bus-side initiator for a 4-channel A/D port. When triggered by a start
//   pulse or a vblank rising edge, it scans each enabled channel in turn:
//   it places the channel address on a, pulses wr_n to start a conversion,
//   waits out the conversion time, pulses rd_n, and captures the low byte of
//   data_in. Control logic can read the captured stick values without a CPU
//   bus cycle.
//
// Parameters
//   WR_CYCLES   wr_n low time per channel, in cycles (>=1)
//   CONV_CYCLES idle wait between wr_n release and rd_n assert (>=1)
//   RD_CYCLES   rd_n low time; data sampled on the last rd_n-low edge (>=2)
//   USE_VBLANK  1: a vblank rising edge triggers a scan; 0: start only
//
// Ports
//   clk6m    in   6 MHz system clock, rising edge
//   reset    in   synchronous, active-high
//   vblank   in   vertical blank level
//   start    in   one-cycle scan request
//   chan_en  in   [3:0] channel enable mask, latched at trigger
//   a        out  [1:0] channel address to A/D
//   wr_n     out  start-conversion strobe, active low
//   rd_n     out  read strobe, active low
//   data_in  in   [15:0] A/D read data, only [7:0] used
//   results  out  [31:0] {ch3,ch2,ch1,ch0} captured bytes
//   valid    out  [3:0] sticky per-channel captured flags
//   busy     out  scan in progress
//   done     out  one-cycle pulse at scan end
//   overrun  out  one-cycle pulse when a trigger arrives while busy
// ---------------------------------------------------------------------------
module adc_scan_master #(
  parameter int unsigned WR_CYCLES   = 2,
  parameter int unsigned CONV_CYCLES = 8,
  parameter int unsigned RD_CYCLES   = 2,
  parameter bit          USE_VBLANK  = 1'b1
) (
  input  logic        clk6m,
  input  logic        reset,
  input  logic        vblank,
  input  logic        start,
  input  logic [3:0]  chan_en,
  output logic [1:0]  a,
  output logic        wr_n,
  output logic        rd_n,
  input  logic [15:0] data_in,
  output logic [31:0] results,
  output logic [3:0]  valid,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  // Phase counter holds (phase length - 1) down to 0, so it only needs to
  // represent the largest phase length minus one.
  localparam int unsigned MAX_AB = (WR_CYCLES > CONV_CYCLES) ? WR_CYCLES : CONV_CYCLES;
  localparam int unsigned MAXC   = (MAX_AB > RD_CYCLES) ? MAX_AB : RD_CYCLES;
  localparam int unsigned CW     = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] WR_LOAD   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD   = CW'(RD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WR,
    S_CONV,
    S_RD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    mask_q, mask_d;
  logic [1:0]    ch_q, ch_d;
  logic          vblank_q;

  logic [1:0]    a_q, a_d;
  logic          wr_n_q, wr_n_d;
  logic          rd_n_q, rd_n_d;
  logic [31:0]   results_q, results_d;
  logic [3:0]    valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  logic          trig;
  logic [3:0]    mask_left;
  logic          unused_data_hi;

  // Upper data bus byte is not part of the A/D result.
  assign unused_data_hi = ^data_in[15:8];

  assign trig = start | (USE_VBLANK & vblank & ~vblank_q);

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    results_d = results_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    mask_left = mask_q & ~(4'b0001 << ch_q);

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          if (chan_en == 4'b0000) begin
            done_d = 1'b1;
          end else begin
            mask_d  = chan_en;
            ch_d    = lowest(chan_en);
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        state_d = S_WR;
        cnt_d   = WR_LOAD;
      end
      S_WR: begin
        if (cnt_q == '0) begin
          state_d = S_CONV;
          cnt_d   = CONV_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CONV: begin
        if (cnt_q == '0) begin
          state_d = S_RD;
          cnt_d   = RD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          results_d[{ch_q, 3'b000} +: 8] = data_in[7:0];
          valid_d[ch_q]                  = 1'b1;
          mask_d                         = mask_left;
          if (mask_left != 4'b0000) begin
            ch_d    = lowest(mask_left);
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q != S_IDLE) && trig) begin
      overrun_d = 1'b1;
    end

    // Outputs are registered from the next state so strobes and address
    // change on the same edge as the state they belong to.
    wr_n_d = (state_d != S_WR);
    rd_n_d = (state_d != S_RD);
    a_d    = (state_d == S_IDLE) ? a_q : ch_d;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk6m) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      ch_q      <= '0;
      vblank_q  <= 1'b0;
      a_q       <= '0;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      results_q <= '0;
      valid_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      vblank_q  <= vblank;
      a_q       <= a_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      results_q <= results_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign a       = a_q;
  assign wr_n    = wr_n_q;
  assign rd_n    = rd_n_q;
  assign results = results_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
